// File: rtl/tm1638_ledkey.sv
`default_nettype none
// ============================================================================
// Module      : tm1638_ledkey
// Description : Continuous TM1638 refresh engine (8 digits, 8 LEDs, 8 keys).
//               Define LEDKEY_KEY_DEBOUNCE_EN to require two matching frames
//               before o_keys updates.
// Revision    : 1.0 - initial release
// ============================================================================
module tm1638_ledkey #(
    parameter int         HALF_PERIOD = 25,
    parameter int         READ_WAIT   = 100,
    parameter logic [2:0] BRIGHTNESS  = 3'd7
) (
    input  logic        i_clk,
    input  logic        rst_n,
    input  logic [63:0] i_digits,
    input  logic [7:0]  i_leds,
    output logic [7:0]  o_keys,
    output logic        o_keys_valid,
    output logic        o_ledkey_clk,
    output logic        o_ledkey_stb,
    inout  wire         io_ledkey_dio
);

    localparam int CNT_MAX = (2 * HALF_PERIOD > READ_WAIT) ? 2 * HALF_PERIOD : READ_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HP_LAST   = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] PH_MODE = 2'd0;
    localparam logic [1:0] PH_ADDR = 2'd1;
    localparam logic [1:0] PH_DISP = 2'd2;
    localparam logic [1:0] PH_READ = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        STB_SETUP = 3'd1,
        BIT_LOW   = 3'd2,
        BIT_HIGH  = 3'd3,
        RD_WAIT   = 3'd4,
        STB_HOLD  = 3'd5,
        GAP       = 3'd6
    } state_t;

    state_t           state;
    logic [1:0]       phase;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_cnt;
    logic [4:0]       byte_cnt;
    logic [7:0]       tx_byte;
    logic [63:0]      digits_q;
    logic [7:0]       leds_q;
    logic [7:0]       key_shadow;
    logic             dio_out;
    logic             dio_oe;
    logic             keys_pending;

    logic [4:0]       byte_inc;
    logic [7:0]       next_byte;
    logic [7:0]       first_byte;
    logic             last_byte;
    logic             reading;
    logic [2:0]       key_idx;

    // Byte idx of a phase; ADDR data interleaves digit n and LED n after 0xC0.
    function automatic logic [7:0] byte_for(input logic [1:0] ph, input logic [4:0] idx,
                                            input logic [63:0] dig, input logic [7:0] led);
        logic [3:0] m;
        m        = 4'(idx - 5'd1);
        byte_for = 8'h00;
        case (ph)
            PH_MODE: byte_for = 8'h40;
            PH_ADDR: begin
                if (idx == 5'd0)
                    byte_for = 8'hC0;
                else if (!m[0])
                    byte_for = dig[{m[3:1], 3'b000} +: 8];
                else
                    byte_for = {7'b0, led[m[3:1]]};
            end
            PH_DISP: byte_for = {5'b10001, BRIGHTNESS};
            default: byte_for = 8'h42;
        endcase
    endfunction

    always_comb begin
        byte_inc   = byte_cnt + 5'd1;
        next_byte  = byte_for(phase, byte_inc, digits_q, leds_q);
        first_byte = byte_for(phase, 5'd0, digits_q, leds_q);
        reading    = (phase == PH_READ) && (byte_cnt != 5'd0);
        key_idx    = {bit_cnt[2], 2'(byte_cnt - 5'd1)};
        case (phase)
            PH_ADDR: last_byte = (byte_cnt == 5'd16);
            PH_READ: last_byte = (byte_cnt == 5'd4);
            default: last_byte = 1'b1;
        endcase
    end

    assign io_ledkey_dio = dio_oe ? dio_out : 1'bz;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            phase        <= PH_MODE;
            cnt          <= '0;
            bit_cnt      <= '0;
            byte_cnt     <= '0;
            tx_byte      <= '0;
            digits_q     <= '0;
            leds_q       <= '0;
            key_shadow   <= '0;
            dio_out      <= 1'b0;
            dio_oe       <= 1'b0;
            o_ledkey_clk <= 1'b1;
            o_ledkey_stb <= 1'b1;
            keys_pending <= 1'b0;
        end else begin
            keys_pending <= 1'b0;
            case (state)
                IDLE: begin
                    cnt   <= '0;
                    state <= GAP;
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt          <= '0;
                        o_ledkey_stb <= 1'b0;
                        bit_cnt      <= '0;
                        byte_cnt     <= '0;
                        tx_byte      <= first_byte;
                        if (phase == PH_MODE) begin
                            digits_q <= i_digits;
                            leds_q   <= i_leds;
                        end
                        state <= STB_SETUP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STB_SETUP: begin
                    if (cnt == HP_LAST) begin
                        cnt          <= '0;
                        o_ledkey_clk <= 1'b0;
                        dio_out      <= tx_byte[0];
                        dio_oe       <= 1'b1;
                        state        <= BIT_LOW;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                BIT_LOW: begin
                    if (cnt == HP_LAST) begin
                        cnt          <= '0;
                        o_ledkey_clk <= 1'b1;
                        // Only bits 0 and 4 of each read byte carry key state.
                        if (reading && bit_cnt[1:0] == 2'd0)
                            key_shadow[key_idx] <= io_ledkey_dio;
                        if (bit_cnt == 3'd7 && phase == PH_READ && byte_cnt == 5'd0) begin
                            dio_oe <= 1'b0;
                            state  <= RD_WAIT;
                        end else if (bit_cnt == 3'd7 && last_byte) begin
                            dio_oe <= 1'b0;
                            state  <= STB_HOLD;
                        end else begin
                            state <= BIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                BIT_HIGH: begin
                    if (cnt == HP_LAST) begin
                        cnt          <= '0;
                        o_ledkey_clk <= 1'b0;
                        state        <= BIT_LOW;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt  <= '0;
                            byte_cnt <= byte_inc;
                            tx_byte  <= next_byte;
                            dio_out  <= next_byte[0];
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            dio_out <= tx_byte[bit_cnt + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RD_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        cnt          <= '0;
                        o_ledkey_clk <= 1'b0;
                        bit_cnt      <= '0;
                        byte_cnt     <= 5'd1;
                        state        <= BIT_LOW;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                STB_HOLD: begin
                    if (cnt == HP_LAST) begin
                        cnt          <= '0;
                        o_ledkey_stb <= 1'b1;
                        phase        <= phase + 2'd1;
                        if (phase == PH_READ)
                            keys_pending <= 1'b1;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LEDKEY_KEY_DEBOUNCE_EN
    logic [7:0] prev_keys;
    logic       prev_valid;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_keys       <= '0;
            o_keys_valid <= 1'b0;
            prev_keys    <= '0;
            prev_valid   <= 1'b0;
        end else begin
            o_keys_valid <= 1'b0;
            if (keys_pending) begin
                prev_keys  <= key_shadow;
                prev_valid <= 1'b1;
                if (prev_valid && prev_keys == key_shadow) begin
                    o_keys       <= key_shadow;
                    o_keys_valid <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_keys       <= '0;
            o_keys_valid <= 1'b0;
        end else begin
            o_keys_valid <= keys_pending;
            if (keys_pending)
                o_keys <= key_shadow;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tm1638_ledkey.sv
`default_nettype none
// ============================================================================
// Module      : tb_tm1638_ledkey
// Description : Directed bench with a TM1638 bus decoder and key-scan model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tm1638_ledkey;

    localparam int HP = 25;
    localparam int RW = 100;

`ifdef LEDKEY_KEY_DEBOUNCE_EN
    localparam logic [31:0] KB1 = 32'h0000_0001; localparam logic [7:0] EK1 = 8'h00; localparam logic EV1 = 1'b0;
    localparam logic [31:0] KB2 = 32'h0000_0000; localparam logic [7:0] EK2 = 8'h00; localparam logic EV2 = 1'b0;
    localparam logic [31:0] KB3 = 32'h0000_0000; localparam logic [7:0] EK3 = 8'h00; localparam logic EV3 = 1'b1;
    localparam logic [31:0] KB5 = 32'h0000_0001; localparam logic [7:0] EK5 = 8'h00; localparam logic EV5 = 1'b0;
    localparam logic [31:0] KB6 = 32'h0000_0001; localparam logic [7:0] EK6 = 8'h01; localparam logic EV6 = 1'b1;
`else
    localparam logic [31:0] KB1 = 32'h0000_1001; localparam logic [7:0] EK1 = 8'h21; localparam logic EV1 = 1'b1;
    localparam logic [31:0] KB2 = 32'h0011_0110; localparam logic [7:0] EK2 = 8'h56; localparam logic EV2 = 1'b1;
    localparam logic [31:0] KB3 = 32'h910E_0000; localparam logic [7:0] EK3 = 8'h88; localparam logic EV3 = 1'b1;
    localparam logic [31:0] KB5 = 32'h0000_1001; localparam logic [7:0] EK5 = 8'h21; localparam logic EV5 = 1'b1;
    localparam logic [31:0] KB6 = 32'h1111_1111; localparam logic [7:0] EK6 = 8'hFF; localparam logic EV6 = 1'b1;
`endif
    localparam logic [63:0] DIG1 = 64'h0000_0000_0000_003F;
    localparam logic [63:0] DIG2 = 64'hF0E1_D2C3_B4A5_9687;

    logic        i_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] i_digits = '0;
    logic [7:0]  i_leds = '0;
    logic [7:0]  o_keys;
    logic        o_keys_valid;
    logic        o_ledkey_clk;
    logic        o_ledkey_stb;
    wire         dio;

    logic        model_oe = 1'b0;
    logic        model_val = 1'b0;
    logic [31:0] key_bytes = '0;

    int checks = 0;
    int errors = 0;

    assign dio = model_oe ? model_val : 1'bz;

    tm1638_ledkey dut (
        .i_clk         (i_clk),
        .rst_n         (rst_n),
        .i_digits      (i_digits),
        .i_leds        (i_leds),
        .o_keys        (o_keys),
        .o_keys_valid  (o_keys_valid),
        .o_ledkey_clk  (o_ledkey_clk),
        .o_ledkey_stb  (o_ledkey_stb),
        .io_ledkey_dio (dio)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Bus decoder and TM1638 key-scan model, evaluated mid-cycle.
    logic       p_clk = 1'b1, p_stb = 1'b1, low_dio = 1'b0;
    logic [7:0] acc = '0;
    bit         after_reset = 1'b1, rd_mode = 1'b0, rd_phase = 1'b0, expect_wait = 1'b0;
    int         bitn = 0, phase_byte = 0, rd_bits = 0, last_edge = 0, stb_rise_at = 0;
    int         timing_bad = 0, oe_bad = 0, rd_end_cnt = 0;
    logic [7:0] bytes_q[$];

    always @(negedge i_clk) begin
        if (!rst_n) begin
            p_clk = 1'b1; p_stb = 1'b1; after_reset = 1'b1;
            rd_mode = 1'b0; rd_phase = 1'b0; expect_wait = 1'b0;
            model_oe = 1'b0; bitn = 0;
        end else begin
            if (model_oe && dut.dio_oe) oe_bad++;
            if ((rd_mode || o_ledkey_stb) && dut.dio_oe) oe_bad++;
            if (p_stb && !o_ledkey_stb) begin
                if (!after_reset && (cyc - stb_rise_at) != 2 * HP) timing_bad++;
                after_reset = 1'b0; last_edge = cyc; bitn = 0; phase_byte = 0; rd_phase = 1'b0;
            end
            if (!p_stb && o_ledkey_stb) begin
                if ((cyc - last_edge) != HP) timing_bad++;
                stb_rise_at = cyc;
                if (rd_phase) rd_end_cnt++;
            end
            if (p_clk != o_ledkey_clk) begin
                if ((cyc - last_edge) != (expect_wait ? RW : HP)) timing_bad++;
                expect_wait = 1'b0;
                last_edge = cyc;
                if (!o_ledkey_clk) begin
                    if (rd_mode) begin
                        model_val = key_bytes[rd_bits];
                        model_oe  = 1'b1;
                    end
                end else if (rd_mode) begin
                    rd_bits++;
                    if (rd_bits == 32) begin
                        rd_mode  = 1'b0;
                        model_oe = 1'b0;
                    end
                end else begin
                    acc = {low_dio, acc[7:1]};
                    bitn++;
                    if (bitn == 8) begin
                        bitn = 0;
                        bytes_q.push_back(acc);
                        if (phase_byte == 0 && acc == 8'h42) begin
                            rd_mode = 1'b1; rd_phase = 1'b1; rd_bits = 0; expect_wait = 1'b1;
                        end
                        phase_byte++;
                    end
                end
            end
            if (!o_ledkey_clk) low_dio = dio;
            p_clk = o_ledkey_clk;
            p_stb = o_ledkey_stb;
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_stb_fall(input string tag);
        int n = 0;
        while (o_ledkey_stb && n < 300) begin
            step();
            n++;
        end
        checks++;
        assert (n >= 2 * HP && n <= 2 * HP + 2)
        else begin
            errors++;
            $error("FAIL %s observed=%0d cycles expected=%0d..%0d", tag, n, 2 * HP, 2 * HP + 2);
        end
    endtask

    task automatic end_frame(input logic [7:0] exp_keys, input logic exp_valid, input string tag);
        int start = rd_end_cnt;
        int n = 0;
        while (rd_end_cnt == start && n < 20000) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 64'(n < 20000), 64'd1);
        chk({tag, "_valid"}, 64'(o_keys_valid), 64'(exp_valid));
        chk({tag, "_keys"}, 64'(o_keys), 64'(exp_keys));
        step();
        chk({tag, "_pulse_end"}, 64'(o_keys_valid), 64'd0);
    endtask

    task automatic check_frame(input logic [63:0] dig, input logic [7:0] led, input string tag);
        logic [7:0] exp [20];
        exp[0]  = 8'h40;
        exp[1]  = 8'hC0;
        for (int n = 0; n < 8; n++) begin
            exp[2 + 2 * n] = dig[8 * n +: 8];
            exp[3 + 2 * n] = {7'b0, led[n]};
        end
        exp[18] = 8'h8F;
        exp[19] = 8'h42;
        chk({tag, "_nbytes"}, 64'(bytes_q.size()), 64'd20);
        for (int i = 0; i < 20 && i < bytes_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 64'(bytes_q[i]), 64'(exp[i]));
        bytes_q.delete();
    endtask

    initial begin
        int n;
        i_leds    = 8'hA5;
        i_digits  = DIG1;
        key_bytes = KB1;
        repeat (5) step();
        chk("reset_clk", 64'(o_ledkey_clk), 64'd1);
        chk("reset_stb", 64'(o_ledkey_stb), 64'd1);
        chk("reset_dio_oe", 64'(dut.dio_oe), 64'd0);
        chk("reset_keys", 64'(o_keys), 64'd0);
        chk("reset_valid", 64'(o_keys_valid), 64'd0);

        rst_n = 1'b1;
        wait_stb_fall("first_stb_fall");

        end_frame(EK1, EV1, "f1");
        check_frame(DIG1, 8'hA5, "f1");
        i_digits  = DIG2;
        i_leds    = 8'h00;
        key_bytes = KB2;

        n = 0;
        while (bytes_q.size() < 3 && n < 20000) begin
            step();
            n++;
        end
        chk("f2_addr_reached", 64'(n < 20000), 64'd1);
        i_leds = 8'hFF;
        end_frame(EK2, EV2, "f2");
        check_frame(DIG2, 8'h00, "f2");
        key_bytes = KB3;

        end_frame(EK3, EV3, "f3");
        check_frame(DIG2, 8'hFF, "f3");
        key_bytes = KB5;

        n = 0;
        while (!(bytes_q.size() >= 7 && !o_ledkey_clk) && n < 20000) begin
            step();
            n++;
        end
        chk("f4_mid_addr_reached", 64'(n < 20000), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_stb", 64'(o_ledkey_stb), 64'd1);
        chk("async_rst_clk", 64'(o_ledkey_clk), 64'd1);
        chk("async_rst_dio_oe", 64'(dut.dio_oe), 64'd0);
        chk("async_rst_keys", 64'(o_keys), 64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        bytes_q.delete();
        wait_stb_fall("restart_stb_fall");

        end_frame(EK5, EV5, "f5");
        check_frame(DIG2, 8'hFF, "f5");
        key_bytes = KB6;
        end_frame(EK6, EV6, "f6");
        check_frame(DIG2, 8'hFF, "f6");

        chk("bus_timing_violations", 64'(timing_bad), 64'd0);
        chk("dio_drive_violations", 64'(oe_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
